// File: rtl/pyrxaclwrpack_pkg.sv
// Shared definitions for the ACL RX payload packer: FSM encoding and widths.
package pyrx_pkg;

    // Byte-length width (matches dec_pylenByte) and word-address width.
    localparam int PY_LENW = 10;
    localparam int PY_AW   = 8;

    // Width of one buffer word and of the bit index inside it.
    localparam int WORD_W = 32;
    localparam int BIDX_W = 5;

    // Packer FSM encoding, also exported on the debug state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } pyrx_state_e;

endpackage

// File: rtl/pyrxaclwrpack_if.sv
// Link-controller write port into the ACL RX ping-pong buffer.
// Write semantics: there is no ready; the buffer always accepts. When
// lnctrl_we is high for one cycle, lnctrl_addr and lnctrl_din are valid in
// that same cycle and the word is written. lnctrl_we doubles as the buffer CS.
interface pyrxaclwrpack_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic [AW-1:0] lnctrl_addr;
    logic [DW-1:0] lnctrl_din;
    logic          lnctrl_we;

    // Packer drives the port.
    modport master (
        output lnctrl_addr,
        output lnctrl_din,
        output lnctrl_we
    );

    // Buffer controller receives the port.
    modport slave (
        input lnctrl_addr,
        input lnctrl_din,
        input lnctrl_we
    );
endinterface

// File: rtl/pyrxaclwrpack_bitpacker.sv
// Bit accumulator: places each captured bit at acc[bidx] (LSB first) and
// flags when the word fills. clr discards the current word before the
// capture of this cycle, so a bit arriving with clr becomes bit 0. flush
// (or a full word) empties acc after this cycle's capture.
module pyrx_bitpacker
    import pyrx_pkg::*;
(
    input  logic              clk_6M,
    input  logic              rst,
    input  logic              clr,
    input  logic              cap,
    input  logic              bit_in,
    input  logic              flush,
    output logic              word_full,
    output logic              byte_done,
    output logic [WORD_W-1:0] word_val
);

    logic [WORD_W-1:0] acc_q;
    logic [BIDX_W-1:0] bidx_q;
    logic [WORD_W-1:0] base_acc;
    logic [BIDX_W-1:0] base_idx;

    // Merge this cycle's bit into the (possibly discarded) word.
    always_comb begin
        base_acc  = clr ? '0 : acc_q;
        base_idx  = clr ? '0 : bidx_q;
        word_val  = base_acc;
        if (cap) begin
            word_val[base_idx] = bit_in;
        end
        word_full = cap && (base_idx == BIDX_W'(WORD_W - 1));
        byte_done = cap && (base_idx[2:0] == 3'd7);
    end

    // Hold the accumulated word; empty it once it has been handed off.
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            acc_q  <= '0;
            bidx_q <= '0;
        end else if (word_full || flush) begin
            acc_q  <= '0;
            bidx_q <= '0;
        end else begin
            acc_q  <= word_val;
            bidx_q <= cap ? (base_idx + BIDX_W'(1)) : base_idx;
        end
    end

endmodule

// File: rtl/pyrxaclwrpack.sv
// ACL RX payload packer: packs the decoded payload bitstream LSB-first into
// 32-bit words and writes them from word address 0 upward into the free
// ping-pong buffer, stopping after the announced byte length.
// Input strobe semantics: py_start_p, dec_pybit_valid_p and py_abort_p are
// single-cycle pulses that are always accepted (no backpressure). A bit on
// the start cycle is bit 0 of the new packet; start beats abort.
module pyrxaclwrpack
    import pyrx_pkg::*;
#(
    parameter int LENW = PY_LENW,
    parameter int AW   = PY_AW
) (
    input  logic            clk_6M,
    input  logic            rst,
    input  logic            py_start_p,
    input  logic [LENW-1:0] dec_pylenByte,
    input  logic            dec_pybit_valid_p,
    input  logic            dec_pybit,
    input  logic            py_abort_p,
    pyrxaclwrpack_if.master wr,
    output logic            py_wrdone_p,
    output logic            py_overrun,
    output logic [LENW-1:0] py_bytecnt,
    output pyrx_state_e     py_state
);

    pyrx_state_e       state_q;
    logic [LENW-1:0]   len_q;
    logic [LENW-1:0]   bytecnt_q;
    logic [AW-1:0]     addr_q;
    logic [WORD_W-1:0] din_q;
    logic              we_q;
    logic              wrdone_q;
    logic              overrun_q;
    logic              armed_q;   // a packet finished and no new start yet

    logic              cap;
    logic              clr;
    logic              flush;
    logic              stray;
    logic              all_rcvd;
    logic              late_state;
    logic              last_bit;
    logic [LENW-1:0]   cnt_base;
    logic [LENW-1:0]   cnt_next;
    logic              word_full;
    logic              byte_done;
    logic [WORD_W-1:0] word_val;

    pyrx_bitpacker u_packer (
        .clk_6M    (clk_6M),
        .rst       (rst),
        .clr       (clr),
        .cap       (cap),
        .bit_in    (dec_pybit),
        .flush     (flush),
        .word_full (word_full),
        .byte_done (byte_done),
        .word_val  (word_val)
    );

    // Decide whether this cycle's bit belongs to the packet and whether it ends it.
    always_comb begin
        all_rcvd   = (bytecnt_q == len_q);
        late_state = (state_q == ST_DONE) || (state_q == ST_FLUSH) ||
                     ((state_q == ST_PACK) && all_rcvd) ||
                     ((state_q == ST_IDLE) && armed_q);
        if (py_start_p) begin
            cap   = dec_pybit_valid_p && (dec_pylenByte != '0);
            stray = dec_pybit_valid_p && (dec_pylenByte == '0);
        end else begin
            cap   = dec_pybit_valid_p && !py_abort_p &&
                    (state_q == ST_PACK) && !all_rcvd;
            stray = dec_pybit_valid_p && !py_abort_p && late_state;
        end
        clr      = py_start_p || py_abort_p;
        cnt_base = py_start_p ? '0 : bytecnt_q;
        cnt_next = byte_done ? (cnt_base + LENW'(1)) : cnt_base;
        last_bit = !py_start_p && byte_done && (cnt_next == len_q);
        flush    = last_bit && !word_full;
    end

    // Packer FSM with registered write port, done pulse, overrun and byte count.
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            bytecnt_q <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            wrdone_q  <= 1'b0;
            overrun_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            we_q     <= 1'b0;
            wrdone_q <= 1'b0;
            if (we_q) begin
                addr_q <= addr_q + AW'(1);
            end
            if (stray) begin
                overrun_q <= 1'b1;
            end
            if (py_start_p) begin
                len_q     <= dec_pylenByte;
                bytecnt_q <= '0;
                addr_q    <= '0;
                overrun_q <= stray;
                armed_q   <= 1'b0;
                if (dec_pylenByte == '0) begin
                    state_q  <= ST_DONE;
                    wrdone_q <= 1'b1;
                end else begin
                    state_q <= ST_PACK;
                end
            end else if (py_abort_p) begin
                state_q <= ST_IDLE;
                armed_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_PACK: begin
                        bytecnt_q <= cnt_next;
                        // Full word or final (possibly partial) word goes out now.
                        if (word_full || last_bit) begin
                            we_q  <= 1'b1;
                            din_q <= word_val;
                        end
                        // A full final word stays one cycle in PACK while it is written.
                        if (flush) begin
                            state_q <= ST_FLUSH;
                        end else if (all_rcvd) begin
                            state_q  <= ST_DONE;
                            wrdone_q <= 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        state_q  <= ST_DONE;
                        wrdone_q <= 1'b1;
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        armed_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign wr.lnctrl_addr = addr_q;
    assign wr.lnctrl_din  = din_q;
    assign wr.lnctrl_we   = we_q;
    assign py_wrdone_p    = wrdone_q;
    assign py_overrun     = overrun_q;
    assign py_bytecnt     = bytecnt_q;
    assign py_state       = state_q;

endmodule

// File: tb/tb_pyrxaclwrpack.sv
// Bench for the ACL RX payload packer: random payloads, expected words and
// their cycles predicted from the byte array, checked at negedge.
module tb_pyrxaclwrpack;
    import pyrx_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk_6M = 1'b0;
    logic        rst;
    logic        py_start_p;
    logic [9:0]  dec_pylenByte;
    logic        dec_pybit_valid_p;
    logic        dec_pybit;
    logic        py_abort_p;
    logic        py_wrdone_p;
    logic        py_overrun;
    logic [9:0]  py_bytecnt;
    pyrx_state_e py_state;
    int          cyc = 0;

    pyrxaclwrpack_if #(.AW(8), .DW(32)) wr_if ();

    pyrxaclwrpack #(.LENW(10), .AW(8)) dut (
        .clk_6M            (clk_6M),
        .rst               (rst),
        .py_start_p        (py_start_p),
        .dec_pylenByte     (dec_pylenByte),
        .dec_pybit_valid_p (dec_pybit_valid_p),
        .dec_pybit         (dec_pybit),
        .py_abort_p        (py_abort_p),
        .wr                (wr_if),
        .py_wrdone_p       (py_wrdone_p),
        .py_overrun        (py_overrun),
        .py_bytecnt        (py_bytecnt),
        .py_state          (py_state)
    );

    always #5 clk_6M = ~clk_6M;
    always @(posedge clk_6M) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  pay [0:1023];
    logic [31:0] exp_q[$];
    logic [7:0]  exp_addr_q[$];
    int          exp_cyc_q[$];
    int          done_exp_cyc = -1;
    bit          done_seen;
    int          we_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Word k of a len-byte payload: bytes 4k..4k+3, little-endian, zero beyond len.
    function automatic logic [31:0] model_word(input int k, input int len);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            if (4 * k + b < len) w[8*b +: 8] = pay[4*k + b];
        end
        return w;
    endfunction

    // Monitor: every write and done pulse must match a prediction.
    always @(negedge clk_6M) begin
        if (wr_if.lnctrl_we === 1'b1) begin
            we_cnt++;
            check("we_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("wr_data", wr_if.lnctrl_din, exp_q.pop_front());
                check("wr_addr", 32'(wr_if.lnctrl_addr), 32'(exp_addr_q.pop_front()));
                check("wr_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
            end
        end
        if (py_wrdone_p === 1'b1) begin
            check("done_expected", 32'(done_exp_cyc >= 0), 32'd1);
            if (done_exp_cyc >= 0) begin
                check("done_cycle", 32'(cyc), 32'(done_exp_cyc));
                done_seen    = 1'b1;
                done_exp_cyc = -1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_pay(input int len);
        for (int i = 0; i < len; i++) pay[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic drive_bit(input int i, input int len);
        int nbits;
        nbits = 8 * len;
        dec_pybit_valid_p = 1'b1;
        dec_pybit         = pay[i / 8][i % 8];
        if ((i % 32 == 31) || (i == nbits - 1)) begin
            exp_q.push_back(model_word(i / 32, len));
            exp_addr_q.push_back(8'(i / 32));
            exp_cyc_q.push_back(cyc + 1);
        end
        if (i == nbits - 1) done_exp_cyc = cyc + 2;
    endtask

    task automatic send_pkt(input int len, input bit b2b, input bit bit_with_start,
                            input bit abort_with_start, input int stop_after, input bit do_abort);
        int lim;
        int i;
        int gap;
        lim = ((stop_after >= 0) && (stop_after < 8 * len)) ? stop_after : 8 * len;
        we_cnt = 0;
        done_seen = 1'b0;
        done_exp_cyc = -1;
        @(posedge clk_6M); #1;
        py_start_p    = 1'b1;
        dec_pylenByte = len[9:0];
        py_abort_p    = abort_with_start;
        i = 0;
        if (len == 0) done_exp_cyc = cyc + 1;
        if (bit_with_start && (lim > 0)) begin
            drive_bit(0, len);
            i = 1;
        end
        @(posedge clk_6M); #1;
        py_start_p = 1'b0;
        py_abort_p = 1'b0;
        dec_pybit_valid_p = 1'b0;
        while (i < lim) begin
            if (!b2b) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin @(posedge clk_6M); #1; end
            end
            drive_bit(i, len);
            @(posedge clk_6M); #1;
            dec_pybit_valid_p = 1'b0;
            i++;
        end
        if (do_abort) begin
            py_abort_p = 1'b1;
            @(posedge clk_6M); #1;
            py_abort_p = 1'b0;
        end
    endtask

    task automatic finish_pkt(input int len);
        repeat (4) @(posedge clk_6M);
        #1;
        check("bytecnt", 32'(py_bytecnt), 32'(len));
        check("we_count", 32'(we_cnt), 32'((len + 3) / 4));
        check("done_seen", 32'(done_seen), 32'd1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("state_idle", 32'(py_state), 32'(ST_IDLE));
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_addr"}, 32'(wr_if.lnctrl_addr), 32'd0);
        check({pfx, "_din"}, wr_if.lnctrl_din, 32'd0);
        check({pfx, "_we"}, 32'(wr_if.lnctrl_we), 32'd0);
        check({pfx, "_wrdone"}, 32'(py_wrdone_p), 32'd0);
        check({pfx, "_overrun"}, 32'(py_overrun), 32'd0);
        check({pfx, "_bytecnt"}, 32'(py_bytecnt), 32'd0);
        check({pfx, "_state"}, 32'(py_state), 32'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int len;
        rst = 1'b1;
        py_start_p = 1'b0;
        dec_pylenByte = '0;
        dec_pybit_valid_p = 1'b0;
        dec_pybit = 1'b0;
        py_abort_p = 1'b0;
        repeat (3) @(posedge clk_6M);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // Single full word.
        pay[0] = 8'h78; pay[1] = 8'h56; pay[2] = 8'h34; pay[3] = 8'h12;
        send_pkt(4, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        finish_pkt(4);
        check("overrun_clean", 32'(py_overrun), 32'd0);

        // One full word plus a one-byte flush.
        for (int i = 0; i < 5; i++) pay[i] = 8'(i + 1);
        send_pkt(5, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        finish_pkt(5);

        // Zero length, then a stray bit.
        send_pkt(0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        finish_pkt(0);
        dec_pybit_valid_p = 1'b1;
        dec_pybit = 1'b1;
        @(posedge clk_6M); #1;
        dec_pybit_valid_p = 1'b0;
        repeat (2) @(posedge clk_6M);
        #1;
        check("overrun_stray", 32'(py_overrun), 32'd1);
        check("stray_no_write", 32'(we_cnt), 32'd0);

        // DH5 length, back-to-back, first bit with the start.
        fill_pay(339);
        send_pkt(339, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        finish_pkt(339);
        check("overrun_cleared", 32'(py_overrun), 32'd0);

        // Abort after 20 bits, then a clean length-4 packet.
        fill_pay(10);
        send_pkt(10, 1'b1, 1'b0, 1'b0, 20, 1'b1);
        repeat (3) @(posedge clk_6M);
        #1;
        check("abort_no_write", 32'(we_cnt), 32'd0);
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_idle", 32'(py_state), 32'(ST_IDLE));
        fill_pay(4);
        send_pkt(4, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        finish_pkt(4);

        // Reset in the middle of a packet, after one word went out.
        fill_pay(8);
        send_pkt(8, 1'b1, 1'b0, 1'b0, 40, 1'b0);
        check("pre_rst_bytecnt", 32'(py_bytecnt), 32'd5);
        rst = 1'b1;
        @(posedge clk_6M); #1;
        check_reset_vals("midrst");
        rst = 1'b0;

        // Start coincident with abort: start wins.
        fill_pay(6);
        send_pkt(6, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        finish_pkt(6);

        // Restart in PACK: first packet cut after 50 bits.
        fill_pay(12);
        send_pkt(12, 1'b1, 1'b0, 1'b0, 50, 1'b0);
        fill_pay(7);
        send_pkt(7, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        finish_pkt(7);

        // Random packets.
        for (int n = 0; n < 8; n++) begin
            len = $urandom_range(1, 40);
            fill_pay(len);
            send_pkt(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, -1, 1'b0);
            finish_pkt(len);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pyrxaclwrpack.md
# pyrxaclwrpack

Receive-side payload packer that sits directly upstream of the ACL RX ping-pong buffer controller. It takes the decoded, de-whitened, FEC-corrected payload bitstream one bit at a time and packs it LSB-first into 32-bit words. It drives the controller's link-controller write port (`lnctrl_addr` / `lnctrl_din` / `lnctrl_we`) so each received payload lands at word address 0 upward of the currently free buffer. It stops by itself after `dec_pylenByte` bytes, flushes a final partial word, and reports completion or overrun.

## Interface
Parameters:
- `LENW`, 10: byte-length width, matching `dec_pylenByte`.
- `AW`, 8: word-address width; the buffer is 256 × 32.

Ports:
- `clk_6M` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `py_start_p` in 1: one-cycle pulse at the payload's first bit slot; samples `dec_pylenByte`.
- `dec_pylenByte` in 10: payload length in bytes; valid when `py_start_p` is high.
- `dec_pybit_valid_p` in 1: one-cycle strobe, a decoded payload bit is present.
- `dec_pybit` in 1: payload bit, over-the-air order (LSB of byte 0 first).
- `py_abort_p` in 1: abort pulse, from HEC fail or slot end; discards the packet.
- `lnctrl_addr` out 8: word write address.
- `lnctrl_din` out 32: word write data.
- `lnctrl_we` out 1: one-cycle write strobe. It also serves as CS for the downstream buffer.
- `py_wrdone_p` out 1: one-cycle pulse after the last word has been written.
- `py_overrun` out 1: sticky flag, set when bits arrive beyond the length. Cleared by `py_start_p`.
- `py_bytecnt` out 10: bytes fully received so far in this packet.

## Operation
- FSM states IDLE, PACK, FLUSH, DONE. Reset state is IDLE.
  - IDLE → PACK on `py_start_p` when the length is nonzero.
  - IDLE → DONE on `py_start_p` when the length is 0. No write occurs.
  - PACK → FLUSH when the last bit of the final byte is captured and the word is partial.
  - PACK → DONE when the last bit completes a full word; that word is written through the normal path.
  - FLUSH → DONE after one cycle.
  - DONE → IDLE after one cycle; `py_wrdone_p` is high during DONE.
- Packing:
  - A 5-bit bit-index `bidx` selects the target bit of a 32-bit shift/accumulate register `acc`.
  - Each captured bit is written to `acc[bidx]`, then `bidx` increments.
  - Byte k of the payload occupies `din[8*(k%4)+7 : 8*(k%4)]` at address `k>>2`.
- Write generation:
  - When `bidx` wraps from 31 to 0, or in FLUSH, `acc` is copied into the `lnctrl_din` register and `lnctrl_we` is pulsed.
  - `acc` is cleared in the same cycle.
  - In a partial flush, unused upper bytes are 0.
- Address:
  - `lnctrl_addr` starts at 0 on each `py_start_p`.
  - It increments in the cycle after each write, modulo 256.
  - Wrap is unreachable for lengths ≤ 1023 bytes.
- Byte count: `py_bytecnt` increments when `bidx[2:0]` wraps.
- Overrun: bits arriving in DONE, or in IDLE after a packet without a new start, are ignored and set `py_overrun`. They produce no write.
- Abort:
  - `py_abort_p` in any state returns the FSM to IDLE the next cycle.
  - A pending write in the abort cycle is suppressed.
  - No flush and no `py_wrdone_p`.
- Restart: `py_start_p` in PACK or FLUSH restarts cleanly. The partial word is discarded, addr and count go to 0, and the new length is latched.
- Simultaneous `py_start_p` and `py_abort_p`: start wins.
- Reset: `rst` mid-packet behaves as abort and returns all outputs to their reset values.

## Timing
- Reset values: `lnctrl_addr`=0, `lnctrl_din`=0, `lnctrl_we`=0, `py_wrdone_p`=0, `py_overrun`=0, `py_bytecnt`=0, FSM=IDLE.
- Write latency: `lnctrl_we` goes high exactly 1 cycle after the strobe carrying the 32nd bit of a word. Address and data are valid in that same cycle.
- Flush latency: the partial-word write occurs 1 cycle after the last bit, in FLUSH. `py_wrdone_p` follows 1 cycle later.
- For a full final word, `py_wrdone_p` is 1 cycle after its `lnctrl_we`.
- Bit strobes may arrive back-to-back every cycle. A strobe arriving in the same cycle as a write is captured into the cleared `acc`; nothing is lost.
- `py_start_p` and `dec_pybit_valid_p` in the same cycle: the bit is bit 0 of the new packet.

## Structure
- Shared package `pyrx_pkg`:
  - FSM state encoding.
  - `LENW` and `AW` constants.
  - Localparam for the 32-bit word width.
- One natural sub-module, `pyrx_bitpacker`: owns `acc`/`bidx` and flags word-full. Write control, addressing and the FSM stay in the top.

## Test plan
- Length 4, bits 0x78,0x56,0x34,0x12 LSB-first, one per cycle → a single write at addr 0 with din=0x12345678, `lnctrl_we` 1 cycle after the 32nd bit, `py_wrdone_p` 1 cycle later, `py_bytecnt`=4.
- Length 5, bytes 0x01..0x05 → writes addr0=0x04030201 and addr1=0x00000005 (flush), then done; exactly 2 `lnctrl_we` pulses.
- Length 0 → no write, `py_wrdone_p` 1 cycle after start; later stray bits set `py_overrun`=1.
- Length 339 (DH5), back-to-back bits → 85 writes at addr 0..84; the last word carries 3 valid bytes with the top byte 0.
- `py_abort_p` after 20 bits of length 10 → no write, no done, FSM IDLE; a following start with length 4 writes at addr 0.
- `rst` asserted during PACK → all outputs at reset values next cycle; `py_start_p` coincident with `py_abort_p` → new packet proceeds.
